// File: rtl/spi_master.sv
// spi_master: command-side SPI initiator sharing clk with the RAM-backed slave.
// Takes {opcode, payload} frames over valid/ready, drives SS_n/MOSI one bit
// per cycle and, for read-data frames, collects the reply byte from MISO.
// Optional build macro SPI_MASTER_AUTO_RD_EN turns opcode 11 into a combined
// read-address + read-data sequence.
module spi_master #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_END   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RECV  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [9:0] tx_shift;
    logic [6:0] rx_shift;
    logic       is_rd;
`ifdef SPI_MASTER_AUTO_RD_EN
    logic       auto_pending;
`endif

    // Handshake and activity flags decode directly from the registered state
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    // Frame sequencer: state, timers, serial shift registers and reply capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            bit_idx  <= 3'd0;
            tx_shift <= 10'd0;
            rx_shift <= 7'd0;
            is_rd    <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
`ifdef SPI_MASTER_AUTO_RD_EN
            auto_pending <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state <= S_SEL;
                        cnt   <= 4'd1;
                        SS_n  <= 1'b0;
                        MOSI  <= cmd_type[1];
`ifdef SPI_MASTER_AUTO_RD_EN
                        if (cmd_type == 2'b11) begin
                            tx_shift     <= {2'b10, cmd_data};
                            is_rd        <= 1'b0;
                            auto_pending <= 1'b1;
                        end else begin
                            tx_shift     <= {cmd_type, cmd_data};
                            is_rd        <= 1'b0;
                            auto_pending <= 1'b0;
                        end
`else
                        tx_shift <= {cmd_type, cmd_data};
                        is_rd    <= (cmd_type == 2'b11);
`endif
                    end
                end
                S_SEL: begin
                    if (cnt == 4'd0) begin
                        state    <= S_SHIFT;
                        cnt      <= 4'd9;
                        MOSI     <= tx_shift[9];
                        tx_shift <= {tx_shift[8:0], 1'b0};
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == 4'd0) begin
                        MOSI  <= 1'b0;
                        state <= is_rd ? S_WAIT : S_END;
                        cnt   <= WAIT_LOAD;
                    end else begin
                        cnt      <= cnt - 4'd1;
                        MOSI     <= tx_shift[9];
                        tx_shift <= {tx_shift[8:0], 1'b0};
                    end
                end
                S_END: begin
                    state <= S_GAP;
                    SS_n  <= 1'b1;
                    cnt   <= GAP_LOAD;
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        rx_shift <= {rx_shift[5:0], MISO};
                        bit_idx  <= 3'd1;
                        state    <= S_RECV;
                        cnt      <= 4'd7;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RECV: begin
                    if (bit_idx == 3'd7) begin
                        rd_data  <= {rx_shift, MISO};
                        rd_valid <= 1'b1;
                        bit_idx  <= 3'd0;
                    end else if (bit_idx != 3'd0) begin
                        rx_shift <= {rx_shift[5:0], MISO};
                        bit_idx  <= bit_idx + 3'd1;
                    end
                    if (cnt == 4'd0) begin
                        state <= S_GAP;
                        SS_n  <= 1'b1;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 4'd0) begin
`ifdef SPI_MASTER_AUTO_RD_EN
                        if (auto_pending) begin
                            auto_pending <= 1'b0;
                            tx_shift     <= {2'b11, 8'h00};
                            is_rd        <= 1'b1;
                            state        <= S_SEL;
                            cnt          <= 4'd1;
                            SS_n         <= 1'b0;
                            MOSI         <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule
